// File: rtl/apb_s_top.sv
// APB slave with a MEM_DEPTH x DATA_WIDTH register file, zero wait states.
// Out-of-range addresses complete with pslverr; presetn is an active-high synchronous reset.
module apb_s_top #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pwrite,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SETUP = 1'b1
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_access;
  logic                  w_valid;
  logic [IDX_W-1:0]      w_idx;

  // An access only counts when it follows a setup; reset masks it so the
  // outputs stay quiet and no write can land while presetn is high.
  assign w_access = !presetn && (r_state == ST_SETUP) && psel && penable;
  assign w_valid  = (32'(paddr) < MEM_DEPTH);
  assign w_idx    = IDX_W'(paddr);

  assign pready  = w_access;
  assign pslverr = w_access && !w_valid;

  // NOTE: always_comb assigns its output a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    prdata = '0;
    if (w_access && !pwrite && w_valid) begin
      prdata = r_mem[w_idx];
    end
  end

  // A setup phase always lands in SETUP; every other case (access, dropped
  // psel, stray psel+penable in IDLE) returns to IDLE.
  // NOTE: sequential state uses non-blocking <= so every flop updates from pre-edge values.
  always_ff @(posedge pclk) begin
    if (presetn) begin
      r_state <= ST_IDLE;
    end else if (psel && !penable) begin
      r_state <= ST_SETUP;
    end else begin
      r_state <= ST_IDLE;
    end
  end

  // NOTE: the array is cleared on reset because its contents must read back as zero afterwards.
  always_ff @(posedge pclk) begin
    if (presetn) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_access && pwrite && w_valid) begin
      r_mem[w_idx] <= pwdata;
    end
  end

endmodule

// File: tb/tb_apb_s_top.sv
// Randomized bench for apb_s_top: stimulus pushes expected access results into a
// queue, a negedge monitor pops them whenever pready is seen and checks idle outputs otherwise.
module tb_apb_s_top;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          pclk    = 1'b0;
  logic          presetn = 1'b1;
  logic [AW-1:0] paddr   = '0;
  logic          psel    = 1'b0;
  logic          penable = 1'b0;
  logic [DW-1:0] pwdata  = '0;
  logic          pwrite  = 1'b0;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  apb_s_top #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwdata  (pwdata),
    .pwrite  (pwrite),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [DW-1:0] prdata;
    logic          pslverr;
  } exp_t;

  exp_t          exp_q [$];
  exp_t          mon_e;
  logic [DW-1:0] model_mem [DEPTH];
  int            vectors     = 0;
  int            miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every completed transfer must match the oldest expectation;
  // outside transfers all outputs must be zero.
  always @(negedge pclk) begin
    if (pready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pready: got pready=1, expected no transfer at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("access_pslverr", 32'(pslverr), 32'(mon_e.pslverr));
        check("access_prdata", 32'(prdata), 32'(mon_e.prdata));
      end
    end else begin
      check("idle_pready", 32'(pready), 32'd0);
      check("idle_pslverr", 32'(pslverr), 32'd0);
      check("idle_prdata", 32'(prdata), 32'd0);
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic idle(input int n);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    presetn = 1'b1;
    psel    = 1'b0;
    penable = 1'b0;
    repeat (2) tick();
    presetn = 1'b0;
    model_clear();
  endtask

  // Full transfer; setup-phase address/direction may differ from the access phase.
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic sw, input logic [AW-1:0] sa);
    exp_t e;
    logic [2:0] ix;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = sw;
    paddr   = sa;
    pwdata  = DW'($urandom);
    tick();
    penable = 1'b1;
    pwrite  = w;
    paddr   = a;
    pwdata  = d;
    ix      = a[2:0];
    e.pslverr = (int'(a) >= DEPTH);
    e.prdata  = (!w && int'(a) < DEPTH) ? model_mem[ix] : '0;
    exp_q.push_back(e);
    tick();
    if (w && int'(a) < DEPTH) model_mem[ix] = d;
  endtask

  task automatic xfer_s(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    xfer(w, a, d, w, a);
  endtask

  // psel+penable with no preceding setup: must have no effect.
  task automatic stray_access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = w;
    paddr   = a;
    pwdata  = d;
    tick();
  endtask

  // Setup dropped by psel=0, then a stray access that must be ignored.
  task automatic aborted_setup(input logic [AW-1:0] a, input logic [DW-1:0] d);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = a;
    pwdata  = d;
    tick();
    idle(1);
    stray_access(1'b1, a, d);
  endtask

  task automatic reset_in_access(input logic [AW-1:0] a, input logic [DW-1:0] d);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = a;
    pwdata  = d;
    tick();
    penable = 1'b1;
    presetn = 1'b1;
    tick();
    presetn = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    model_clear();
  endtask

  initial begin
    int kind;
    model_clear();
    do_reset();

    // Directed scenarios; first transfer starts immediately after reset release.
    xfer_s(1'b1, 4'd1, 8'hAA);
    xfer_s(1'b1, 4'd2, 8'hBB);
    xfer_s(1'b1, 4'd3, 8'hCC);
    idle(1);
    xfer_s(1'b0, 4'd1, 8'h00);
    xfer_s(1'b0, 4'd2, 8'h00);
    xfer_s(1'b0, 4'd3, 8'h00);
    xfer_s(1'b1, 4'hA, 8'hFF);
    xfer_s(1'b0, 4'd2, 8'h00);
    xfer_s(1'b0, 4'hA, 8'h00);
    idle(1);
    stray_access(1'b1, 4'd4, 8'h55);
    idle(1);
    xfer_s(1'b0, 4'd4, 8'h00);
    xfer_s(1'b1, 4'd6, 8'h3C);
    xfer(1'b0, 4'd6, 8'h00, 1'b1, 4'd2);
    reset_in_access(4'd5, 8'h77);
    xfer_s(1'b0, 4'd5, 8'h00);
    xfer_s(1'b0, 4'd1, 8'h00);
    aborted_setup(4'd7, 8'h99);
    idle(1);
    xfer_s(1'b0, 4'd7, 8'h00);

    // Random mix of transfers, stray accesses, aborted setups and resets.
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 19));
      if (kind < 15) begin
        xfer(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
             1'($urandom), AW'($urandom_range(0, 15)));
        if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 2)));
      end else if (kind < 17) begin
        stray_access(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
      end else if (kind < 18) begin
        aborted_setup(AW'($urandom_range(0, 15)), DW'($urandom));
      end else if (kind < 19) begin
        reset_in_access(AW'($urandom_range(0, 7)), DW'($urandom));
      end else begin
        do_reset();
      end
    end

    idle(3);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_s_top.md
APB_S_TOP -- requirements
Module: apb_s_top

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: paddr width.
REQ-002 Parameter DATA_WIDTH, default 8: pwdata/prdata width.
REQ-003 Parameter MEM_DEPTH, default 8: number of storage words; valid addresses are 0..MEM_DEPTH-1.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 pclk  input  1  clock; all state updates on its rising edge.
REQ-006 presetn  input  1  synchronous reset, active-high (asserted when 1) despite the name.
REQ-007 paddr  input  ADDR_WIDTH  transfer address.
REQ-008 psel  input  1  slave select.
REQ-009 penable  input  1  access-phase indicator.
REQ-010 pwdata  input  DATA_WIDTH  write data.
REQ-011 pwrite  input  1  1 = write, 0 = read.
REQ-012 prdata  output  DATA_WIDTH  read data.
REQ-013 pready  output  1  transfer complete.
REQ-014 pslverr  output  1  transfer error.

Function
REQ-015 Storage SHALL be a MEM_DEPTH x DATA_WIDTH register array.
REQ-016 FSM states SHALL be IDLE and SETUP.
REQ-017 Any state, psel=1 & penable=0 at the clock edge -> SETUP.
REQ-018 SETUP, psel=1 & penable=1 at the edge (access cycle) -> IDLE.
REQ-019 SETUP, psel=0 at the edge -> IDLE, with no transfer.
REQ-020 An access cycle SHALL be defined as state==SETUP & psel=1 & penable=1.
REQ-021 psel=1 & penable=1 while in IDLE (no preceding setup) SHALL be ignored: pready=0, pslverr=0, no memory change.
REQ-022 pready SHALL equal 1 combinationally during an access cycle and 0 otherwise (zero wait states).
REQ-023 An address SHALL be invalid when paddr >= MEM_DEPTH (default: paddr[3]=1, e.g. 0xA).
REQ-024 pslverr SHALL equal 1 combinationally during an access cycle with an invalid address and 0 otherwise.
REQ-025 Write: at the edge ending an access cycle with pwrite=1 and a valid address, mem[paddr] <= pwdata.
REQ-026 An invalid-address write SHALL leave memory unchanged.
REQ-027 Read: during an access cycle with pwrite=0 and a valid address, prdata SHALL equal mem[paddr] combinationally.
REQ-028 Read: during an access cycle with pwrite=0 and an invalid address, prdata SHALL be 0.
REQ-029 Outside read access cycles, prdata SHALL be 0.
REQ-030 Back-to-back transfers (setup immediately after access) SHALL be supported with no idle cycle.
REQ-031 A change of paddr/pwrite between setup and access SHALL be ignored; access-cycle values are used.

Reset
REQ-032 While presetn=1 at a rising edge: state <= IDLE and all memory words <= 0.
REQ-033 During reset, pready=0, pslverr=0 and prdata=0 regardless of other inputs.
REQ-034 Reset asserted during an access cycle SHALL abort the transfer with no memory write.
REQ-035 The first transfer SHALL be accepted starting with the setup cycle after reset deasserts.

Verification
REQ-036 Reset, then write 0xAA/0xBB/0xCC to addresses 1/2/3 -> pready=1 and pslverr=0 in each access cycle.
REQ-037 Read addresses 1/2/3 after those writes -> prdata=0xAA/0xBB/0xCC in the access cycle, pslverr=0.
REQ-038 Write 0xFF to address 0xA -> pready=1, pslverr=1 in the access cycle; a subsequent read of 0x2 still returns 0xBB.
REQ-039 Read address 0xA -> pready=1, pslverr=1, prdata=0x00.
REQ-040 psel=1 & penable=1 with no setup cycle, write 0x55 to address 4 -> pready=0; later read of 4 returns 0x00.
REQ-041 Reset asserted during the access cycle of a write of 0x77 to address 5 -> afterwards a read of 5 returns 0x00 and a read of 1 returns 0x00.
